// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP state machine with DR/IR enable decode, bypass register and TDO steering.
// Optional DR bit counter output (drBitCount) is built when TAP_DR_BITCOUNT_EN is defined.
module tap_controller #(
  parameter logic [1:0] BSCAN_CODE  = 2'b00,
  parameter logic [1:0] BYPASS_CODE = 2'b01,
  parameter logic [1:0] ISCAN_CODE  = 2'b10,
  parameter logic [1:0] BIST_CODE   = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        TMS,
  input  logic        TDI,
  input  logic [1:0]  instruction,
  input  logic        irTDO,
  input  logic        bsTDO,
  input  logic        scanTDO,
  input  logic        bistTDO,
  output logic [3:0]  tapState,
  output logic        irShiftEn,
  output logic        irUpdateEn,
  output logic        irRst,
  output logic        bsClkEn,
  output logic        bsUpdateEn,
  output logic        shiftLoad,
  output logic        testNorm,
  output logic        scanEn,
  output logic        bistStart,
  output logic        TDO
`ifdef TAP_DR_BITCOUNT_EN
  ,
  output logic [15:0] drBitCount
`endif
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    TLR     = 4'hF,
    RTI     = 4'hC,
    SEL_DR  = 4'h7,
    CAP_DR  = 4'h6,
    SH_DR   = 4'h2,
    EX1_DR  = 4'h1,
    PAUSE_DR= 4'h3,
    EX2_DR  = 4'h0,
    UPD_DR  = 4'h5,
    SEL_IR  = 4'h4,
    CAP_IR  = 4'hE,
    SH_IR   = 4'hA,
    EX1_IR  = 4'h9,
    PAUSE_IR= 4'hB,
    EX2_IR  = 4'h8,
    UPD_IR  = 4'hD
  } tap_state_e;

  tap_state_e state;
  tap_state_e state_next;
  logic       bypass;
  logic       dr_tdo;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TLR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state graph and enable decode
  always_comb begin
    state_next = state;
    irRst      = 1'b0;
    irShiftEn  = 1'b0;
    irUpdateEn = 1'b0;
    bsClkEn    = 1'b0;
    bsUpdateEn = 1'b0;
    shiftLoad  = 1'b0;
    testNorm   = 1'b0;
    scanEn     = 1'b0;
    bistStart  = 1'b0;

    case (state)
      TLR:      state_next = TMS ? TLR    : RTI;
      RTI:      state_next = TMS ? SEL_DR : RTI;
      SEL_DR:   state_next = TMS ? SEL_IR : CAP_DR;
      CAP_DR:   state_next = TMS ? EX1_DR : SH_DR;
      SH_DR:    state_next = TMS ? EX1_DR : SH_DR;
      EX1_DR:   state_next = TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_next = TMS ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_next = TMS ? UPD_DR : SH_DR;
      UPD_DR:   state_next = TMS ? SEL_DR : RTI;
      SEL_IR:   state_next = TMS ? TLR    : CAP_IR;
      CAP_IR:   state_next = TMS ? EX1_IR : SH_IR;
      SH_IR:    state_next = TMS ? EX1_IR : SH_IR;
      EX1_IR:   state_next = TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_next = TMS ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_next = TMS ? UPD_IR : SH_IR;
      UPD_IR:   state_next = TMS ? SEL_DR : RTI;
      default:  state_next = TLR;
    endcase

    irRst      = (state == TLR);
    irShiftEn  = (state == CAP_IR) || (state == SH_IR);
    irUpdateEn = (state == UPD_IR);
    bsClkEn    = ((state == CAP_DR) || (state == SH_DR)) && (instruction == BSCAN_CODE);
    bsUpdateEn = (state == UPD_DR) && (instruction == BSCAN_CODE);
    shiftLoad  = (state == SH_DR);
    testNorm   = (instruction == BSCAN_CODE) && (state != TLR);
    scanEn     = (state == SH_DR) && (instruction == ISCAN_CODE);
    bistStart  = (state == UPD_DR) && (instruction == BIST_CODE);
  end

  assign tapState = state;

  // Data-register serial source for the current instruction
  always_comb begin
    dr_tdo = bsTDO;
    case (instruction)
      BSCAN_CODE:  dr_tdo = bsTDO;
      BYPASS_CODE: dr_tdo = bypass;
      ISCAN_CODE:  dr_tdo = scanTDO;
      BIST_CODE:   dr_tdo = bistTDO;
      default:     dr_tdo = bsTDO;
    endcase
  end

  // Bypass register: zero on capture, TDI on shift
  always_ff @(posedge clk) begin
    if (rst) begin
      bypass <= 1'b0;
    end else if (instruction == BYPASS_CODE) begin
      if (state == CAP_DR) begin
        bypass <= 1'b0;
      end else if (state == SH_DR) begin
        bypass <= TDI;
      end
    end
  end

  // TDO is registered; it only moves in the shift states
  always_ff @(posedge clk) begin
    if (rst) begin
      TDO <= 1'b0;
    end else if (state == SH_IR) begin
      TDO <= irTDO;
    end else if (state == SH_DR) begin
      TDO <= dr_tdo;
    end
  end

`ifdef TAP_DR_BITCOUNT_EN
  // Saturating count of DR shift cycles since the last capture
  always_ff @(posedge clk) begin
    if (rst) begin
      drBitCount <= 16'h0000;
    end else if (state == CAP_DR) begin
      drBitCount <= 16'h0000;
    end else if ((state == SH_DR) && (drBitCount != 16'hFFFF)) begin
      drBitCount <= drBitCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Directed self-checking bench for tap_controller; state walks and enables use hand-computed values.
// Define TAP_DR_BITCOUNT_EN to also exercise the DR bit counter.
module tb_tap_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        TMS;
  logic        TDI;
  logic [1:0]  instruction;
  logic        irTDO, bsTDO, scanTDO, bistTDO;
  logic [3:0]  tapState;
  logic        irShiftEn, irUpdateEn, irRst, bsClkEn, bsUpdateEn;
  logic        shiftLoad, testNorm, scanEn, bistStart, TDO;
`ifdef TAP_DR_BITCOUNT_EN
  logic [15:0] drBitCount;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tap_controller dut (
    .clk         (clk),
    .rst         (rst),
    .TMS         (TMS),
    .TDI         (TDI),
    .instruction (instruction),
    .irTDO       (irTDO),
    .bsTDO       (bsTDO),
    .scanTDO     (scanTDO),
    .bistTDO     (bistTDO),
    .tapState    (tapState),
    .irShiftEn   (irShiftEn),
    .irUpdateEn  (irUpdateEn),
    .irRst       (irRst),
    .bsClkEn     (bsClkEn),
    .bsUpdateEn  (bsUpdateEn),
    .shiftLoad   (shiftLoad),
    .testNorm    (testNorm),
    .scanEn      (scanEn),
    .bistStart   (bistStart),
    .TDO         (TDO)
`ifdef TAP_DR_BITCOUNT_EN
    ,
    .drBitCount  (drBitCount)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One TCK cycle with the given TMS; outputs are sampled 1ns after the edge
  task automatic step(input logic tms);
    TMS = tms;
    @(posedge clk);
    #1;
  endtask

  task automatic step5_ones();
    for (int i = 0; i < 5; i++) step(1'b1);
  endtask

  initial begin
    rst = 1'b1; TMS = 1'b0; TDI = 1'b0; instruction = 2'b01;
    irTDO = 1'b0; bsTDO = 1'b0; scanTDO = 1'b0; bistTDO = 1'b0;
    #2;

    // Reset
    step(1'b0);
    check("rst_state", 16'(tapState), 16'hF);
    check("rst_irRst", 16'(irRst), 16'h1);
    check("rst_tdo",   16'(TDO), 16'h0);
    rst = 1'b0;
    step(1'b0);
    check("rti_after_rst", 16'(tapState), 16'hC);
    check("rti_irRst", 16'(irRst), 16'h0);

    // Five TMS=1 from RTI
    step5_ones();
    check("tlr_from_rti", 16'(tapState), 16'hF);

    // Five TMS=1 from ShDR
    step(1'b0); step(1'b1); step(1'b0); step(1'b0);
    check("reach_shdr", 16'(tapState), 16'h2);
    step5_ones();
    check("tlr_from_shdr", 16'(tapState), 16'hF);

    // Five TMS=1 from PauseIR
    step(1'b0); step(1'b1); step(1'b1); step(1'b0); step(1'b0); step(1'b1); step(1'b0);
    check("reach_pauseir", 16'(tapState), 16'hB);
    step5_ones();
    check("tlr_from_pauseir", 16'(tapState), 16'hF);

    // Five TMS=1 from UpdDR
    step(1'b0); step(1'b1); step(1'b0); step(1'b1); step(1'b1);
    check("reach_upddr", 16'(tapState), 16'h5);
    step5_ones();
    check("tlr_from_upddr", 16'(tapState), 16'hF);

    // IR path
    step(1'b0); step(1'b1); step(1'b1); step(1'b0);
    check("capir_state", 16'(tapState), 16'hE);
    check("capir_shen", 16'(irShiftEn), 16'h1);
    step(1'b0);
    check("shir_state", 16'(tapState), 16'hA);
    check("shir_shen", 16'(irShiftEn), 16'h1);
    irTDO = 1'b1;
    step(1'b1);
    check("ex1ir_state", 16'(tapState), 16'h9);
    check("ir_tdo", 16'(TDO), 16'h1);
    check("ex1ir_shen", 16'(irShiftEn), 16'h0);
    irTDO = 1'b0;
    step(1'b1);
    check("updir_state", 16'(tapState), 16'hD);
    check("updir_upen", 16'(irUpdateEn), 16'h1);
    step(1'b1);
    check("updir_to_seldr", 16'(tapState), 16'h7);
    check("updir_upen_off", 16'(irUpdateEn), 16'h0);

    // Bypass shift TDI=1,0,1,1 -> TDO 0,1,0,1 then holds 1
    instruction = 2'b01;
    step(1'b0);
    check("byp_capdr", 16'(tapState), 16'h6);
    check("byp_bsclk", 16'(bsClkEn), 16'h0);
    check("byp_testnorm", 16'(testNorm), 16'h0);
    step(1'b0);
    TDI = 1'b1; step(1'b0); check("byp_tdo0", 16'(TDO), 16'h0);
    TDI = 1'b0; step(1'b0); check("byp_tdo1", 16'(TDO), 16'h1);
    TDI = 1'b1; step(1'b0); check("byp_tdo2", 16'(TDO), 16'h0);
    TDI = 1'b1; step(1'b1); check("byp_tdo3", 16'(TDO), 16'h1);
    check("byp_ex1dr", 16'(tapState), 16'h1);
    step(1'b1);
    check("byp_tdo_hold", 16'(TDO), 16'h1);
    step(1'b1);

    // Boundary scan
    instruction = 2'b00;
    step(1'b0);
    check("bs_cap_clken", 16'(bsClkEn), 16'h1);
    check("bs_cap_shld", 16'(shiftLoad), 16'h0);
    check("bs_cap_tn", 16'(testNorm), 16'h1);
    step(1'b0);
    check("bs_sh_shld", 16'(shiftLoad), 16'h1);
    check("bs_sh_tn", 16'(testNorm), 16'h1);
    check("bs_sh_clken", 16'(bsClkEn), 16'h1);
    check("bs_sh_scanen", 16'(scanEn), 16'h0);
    bsTDO = 1'b0;
    step(1'b1);
    check("bs_tdo", 16'(TDO), 16'h0);
    check("bs_ex1_clken", 16'(bsClkEn), 16'h0);
    step(1'b1);
    check("bs_upd_en", 16'(bsUpdateEn), 16'h1);
    check("bs_upd_bist", 16'(bistStart), 16'h0);
    step(1'b0);
    check("bs_upd_off", 16'(bsUpdateEn), 16'h0);

    // BIST
    instruction = 2'b11;
    step(1'b1); step(1'b0); step(1'b0);
    check("bist_sh_scanen", 16'(scanEn), 16'h0);
    bistTDO = 1'b1;
    step(1'b1);
    check("bist_tdo", 16'(TDO), 16'h1);
    check("bist_ex1_start", 16'(bistStart), 16'h0);
    step(1'b1);
    check("bist_start", 16'(bistStart), 16'h1);
    step(1'b0);
    check("bist_start_off", 16'(bistStart), 16'h0);

    // Internal scan
    instruction = 2'b10;
    step(1'b1); step(1'b0); step(1'b0);
    check("iscan_scanen", 16'(scanEn), 16'h1);
    scanTDO = 1'b0;
    step(1'b1);
    check("iscan_tdo", 16'(TDO), 16'h0);
    check("iscan_ex1_scanen", 16'(scanEn), 16'h0);

    // Reset in the 3rd ShDR cycle
    instruction = 2'b01;
    step(1'b1); step(1'b1); step(1'b0);
    TDI = 1'b1;
    step(1'b0); step(1'b0); step(1'b0);
    check("mid_shdr", 16'(tapState), 16'h2);
    check("mid_tdo", 16'(TDO), 16'h1);
    rst = 1'b1;
    step(1'b0);
    check("mid_rst_state", 16'(tapState), 16'hF);
    check("mid_rst_tdo", 16'(TDO), 16'h0);
    check("mid_rst_irRst", 16'(irRst), 16'h1);
    instruction = 2'b00;
    #1;
    check("tlr_testnorm", 16'(testNorm), 16'h0);
    rst = 1'b0;

`ifdef TAP_DR_BITCOUNT_EN
    check("cnt_rst", drBitCount, 16'h0000);
    step(1'b0); step(1'b1); step(1'b0); step(1'b0);
    check("cnt_capdr", drBitCount, 16'h0000);
    step(1'b0); step(1'b0); step(1'b0);
    check("cnt_three", drBitCount, 16'h0003);
    for (int i = 0; i < 70000; i++) step(1'b0);
    check("cnt_sat", drBitCount, 16'hFFFF);
    step(1'b1);
    check("cnt_hold", drBitCount, 16'hFFFF);
    step(1'b1); step(1'b1); step(1'b0);
    check("cnt_cap_state", 16'(tapState), 16'h6);
    step(1'b0);
    check("cnt_cleared", drBitCount, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
